slave_port: RTL

SLAVE_PORT -- requirements
Module: slave_port

---
 rtl/slave_port.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/slave_port.sv
// slave_port: bit-serial bus slave bridging to a simple synchronous memory
// port. A transaction starts with a serial header (address plus burst count,
// both LSB first), then either collects write words from rx_data and
// issues one memory write per word, or fetches words from memory and
// streams them out on tx_data under master_ready flow control.
// BURST_LEN must not exceed ADDR_LEN: burst bits ride alongside the address
// bits, and any burst bits beyond BURST_LEN are dropped.

module slave_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                slave_sel,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_burst_number,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic                tx_done,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    localparam int HCW = $clog2(ADDR_LEN + 1);
    localparam int BCW = $clog2(DATA_LEN + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        WMEM  = 3'd3,
        RREQ  = 3'd4,
        RWAIT = 3'd5,
        SEND  = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t               state_r;
    state_t               state_next_s;

    logic [ADDR_LEN-1:0]  addr_r;
    logic [ADDR_LEN-1:0]  burst_sh_r;
    logic [HCW-1:0]       hdr_cnt_r;
    logic                 is_write_r;
    logic [BURST_LEN-1:0] words_left_r;
    logic [DATA_LEN-1:0]  wdata_r;
    logic [DATA_LEN-1:0]  shift_r;
    logic [BCW-1:0]       bit_cnt_r;

    logic                 start_s;
    logic                 abort_s;
    logic                 hdr_last_s;
    logic                 wbit_last_s;
    logic                 sbit_last_s;
    logic                 last_word_s;
    logic [ADDR_LEN-1:0]  addr_shift_s;
    logic [ADDR_LEN-1:0]  burst_shift_s;
    logic [BURST_LEN-1:0] burst_count_s;

    // A start needs exactly one of write/read; both or neither is ignored.
    assign start_s     = slave_sel & master_valid & (write_en ^ read_en);
    // Losing the select anywhere outside IDLE throws the transaction away.
    assign abort_s     = (state_r != IDLE) & ~slave_sel;
    assign hdr_last_s  = (state_r == HDR) & master_valid
                         & (hdr_cnt_r == HCW'(ADDR_LEN - 1));
    assign wbit_last_s = (state_r == WDATA) & master_valid
                         & (bit_cnt_r == BCW'(DATA_LEN - 1));
    assign sbit_last_s = (state_r == SEND) & master_ready
                         & (bit_cnt_r == BCW'(DATA_LEN - 1));
    assign last_word_s = (words_left_r == BURST_LEN'(1));

    // Header bits enter at the top and move down, so after ADDR_LEN shifts
    // the first (LSB) bit sits at index 0.
    assign addr_shift_s  = {rx_address, addr_r[ADDR_LEN-1:1]};
    assign burst_shift_s = {rx_burst_number, burst_sh_r[ADDR_LEN-1:1]};
    assign burst_count_s = burst_shift_s[BURST_LEN-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; an abort overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_next_s = HDR;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                HDR: begin
                    if (hdr_last_s) begin
                        state_next_s = is_write_r ? WDATA : RREQ;
                    end else begin
                        state_next_s = HDR;
                    end
                end
                WDATA: begin
                    if (wbit_last_s) begin
                        state_next_s = WMEM;
                    end else begin
                        state_next_s = WDATA;
                    end
                end
                WMEM: begin
                    if (last_word_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = WDATA;
                    end
                end
                RREQ:  state_next_s = RWAIT;
                RWAIT: state_next_s = SEND;
                SEND: begin
                    if (sbit_last_s) begin
                        state_next_s = last_word_s ? DONE : RREQ;
                    end else begin
                        state_next_s = SEND;
                    end
                end
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Header capture, burst bookkeeping and address advance per word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r       <= {ADDR_LEN{1'b0}};
            burst_sh_r   <= {ADDR_LEN{1'b0}};
            hdr_cnt_r    <= {HCW{1'b0}};
            is_write_r   <= 1'b0;
            words_left_r <= {BURST_LEN{1'b0}};
        end else if (abort_s) begin
            addr_r       <= {ADDR_LEN{1'b0}};
            burst_sh_r   <= {ADDR_LEN{1'b0}};
            hdr_cnt_r    <= {HCW{1'b0}};
            is_write_r   <= 1'b0;
            words_left_r <= {BURST_LEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        addr_r       <= {rx_address, {(ADDR_LEN-1){1'b0}}};
                        burst_sh_r   <= {rx_burst_number, {(ADDR_LEN-1){1'b0}}};
                        hdr_cnt_r    <= HCW'(1);
                        is_write_r   <= write_en;
                        words_left_r <= {BURST_LEN{1'b0}};
                    end
                end
                HDR: begin
                    if (master_valid) begin
                        addr_r     <= addr_shift_s;
                        burst_sh_r <= burst_shift_s;
                        if (hdr_last_s) begin
                            hdr_cnt_r <= {HCW{1'b0}};
                            // A zero burst count still moves one word.
                            words_left_r <= (burst_count_s == {BURST_LEN{1'b0}})
                                            ? BURST_LEN'(1) : burst_count_s;
                        end else begin
                            hdr_cnt_r <= hdr_cnt_r + HCW'(1);
                        end
                    end
                end
                WMEM: begin
                    // Natural overflow gives the silent wrap to address 0.
                    addr_r <= addr_r + ADDR_LEN'(1);
                    if (!last_word_s) begin
                        words_left_r <= words_left_r - BURST_LEN'(1);
                    end
                end
                SEND: begin
                    if (sbit_last_s) begin
                        addr_r <= addr_r + ADDR_LEN'(1);
                        if (!last_word_s) begin
                            words_left_r <= words_left_r - BURST_LEN'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Serial data path: assemble write words, unload read words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdata_r   <= {DATA_LEN{1'b0}};
            shift_r   <= {DATA_LEN{1'b0}};
            bit_cnt_r <= {BCW{1'b0}};
        end else if (abort_s) begin
            wdata_r   <= {DATA_LEN{1'b0}};
            shift_r   <= {DATA_LEN{1'b0}};
            bit_cnt_r <= {BCW{1'b0}};
        end else begin
            case (state_r)
                WDATA: begin
                    if (master_valid) begin
                        wdata_r   <= {rx_data, wdata_r[DATA_LEN-1:1]};
                        bit_cnt_r <= wbit_last_s ? {BCW{1'b0}} : bit_cnt_r + BCW'(1);
                    end
                end
                RWAIT: begin
                    shift_r   <= mem_rdata;
                    bit_cnt_r <= {BCW{1'b0}};
                end
                SEND: begin
                    // Hold the current bit until the master takes it.
                    if (master_ready) begin
                        shift_r   <= {1'b0, shift_r[DATA_LEN-1:1]};
                        bit_cnt_r <= sbit_last_s ? {BCW{1'b0}} : bit_cnt_r + BCW'(1);
                    end
                end
                IDLE: begin
                    bit_cnt_r <= {BCW{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from the state register and held registers, so
    // reset drives them to their idle values without waiting for a clock.
    assign slave_ready = (state_r == IDLE);
    assign slave_valid = (state_r == SEND);
    assign tx_done     = (state_r == DONE);
    assign mem_we      = (state_r == WMEM);
    assign mem_re      = (state_r == RREQ);
    assign tx_data     = (state_r == SEND) ? shift_r[0] : 1'b0;
    assign mem_addr    = ((state_r == WMEM) || (state_r == RREQ))
                         ? addr_r : {ADDR_LEN{1'b0}};
    assign mem_wdata   = (state_r == WMEM) ? wdata_r : {DATA_LEN{1'b0}};

endmodule
